// File: rtl/div_unit_if.sv
// Request/response bundle for div_unit: operands and destination go in,
// busy/done/result/rd_out come back toward the register unit.
interface div_unit_if;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   modport master (
      output start, funct3, a, b, rd_in,
      input  busy, done, result, rd_out
   );

   modport slave (
      input  start, funct3, a, b, rd_in,
      output busy, done, result, rd_out
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-bit iterative divider for DIV/DIVU/REM/REMU.
// Fixed latency: request accepted at E0, done visible after E33.
// Radix-2 restoring division on operand magnitudes, followed by one
// sign-correction/select cycle.
module div_unit (
   input  logic      clk,
   input  logic      rst,
   div_unit_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_SIGN,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [4:0]  r_cnt;
   logic [31:0] r_quo;
   logic [31:0] r_rem;
   logic [31:0] r_div;
   logic        r_rem_sel;
   logic        r_a_neg;
   logic        r_b_neg;
   logic        r_b_zero;
   logic [4:0]  r_rd;
   logic [31:0] r_result;
   logic [4:0]  r_rd_out;

   logic        w_accept;
   logic        w_signed_in;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [32:0] w_shift;
   logic        w_ge;
   logic [31:0] w_rem_step;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;
   logic [31:0] w_final;
   logic        w_busy;
   logic        w_done;

   // Request acceptance and operand magnitudes (only M-extension divide ops).
   always_comb begin
      w_accept    = (r_state == S_IDLE) && bus.start && bus.funct3[2];
      w_signed_in = ~bus.funct3[0];
      w_a_mag     = (w_signed_in && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
      w_b_mag     = (w_signed_in && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      w_shift    = {r_rem, r_quo[31]};
      w_ge       = (w_shift >= {1'b0, r_div});
      w_rem_step = w_ge ? (w_shift[31:0] - r_div) : w_shift[31:0];
   end

   // Sign correction and quotient/remainder select.
   // A zero divisor leaves the quotient magnitude at all ones and the
   // remainder at |a|; the quotient is forced so a negative dividend is not
   // negated, while the remainder sign fix already restores a.
   always_comb begin
      w_quo_fix = (r_a_neg ^ r_b_neg) ? (~r_quo + 32'd1) : r_quo;
      w_rem_fix = r_a_neg ? (~r_rem + 32'd1) : r_rem;
      if (r_rem_sel) begin
         w_final = w_rem_fix;
      end else if (r_b_zero) begin
         w_final = '1;
      end else begin
         w_final = w_quo_fix;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and status outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            w_busy = 1'b1;
            if (r_cnt == 5'd31) begin
               w_state_nxt = S_SIGN;
            end
         end
         S_SIGN: begin
            w_busy      = 1'b1;
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_busy      = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: operand latch, iteration, and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_quo     <= '0;
         r_rem     <= '0;
         r_div     <= '0;
         r_rem_sel <= 1'b0;
         r_a_neg   <= 1'b0;
         r_b_neg   <= 1'b0;
         r_b_zero  <= 1'b0;
         r_rd      <= '0;
         r_result  <= '0;
         r_rd_out  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt     <= '0;
                  r_quo     <= w_a_mag;
                  r_rem     <= '0;
                  r_div     <= w_b_mag;
                  r_rem_sel <= bus.funct3[1];
                  r_a_neg   <= w_signed_in && bus.a[31];
                  r_b_neg   <= w_signed_in && bus.b[31];
                  r_b_zero  <= (bus.b == '0);
                  r_rd      <= bus.rd_in;
               end
            end
            S_CALC: begin
               r_rem <= w_rem_step;
               r_quo <= {r_quo[30:0], w_ge};
               r_cnt <= r_cnt + 5'd1;
            end
            S_SIGN: begin
               r_result <= w_final;
               r_rd_out <= r_rd;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy   = w_busy;
   assign bus.done   = w_done;
   assign bus.result = r_result;
   assign bus.rd_out = r_rd_out;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results computed
// with plain 64-bit arithmetic; a negedge monitor pops on every done pulse.
module tb_div_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;

   div_unit_if bus ();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;
   bit          busy_chk_pend = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: truncating division from 64-bit signed arithmetic.
   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb_;
      longint r;
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      case (f)
         3'b100: if (b == 0) r = -1; else r = sa / sb_;
         3'b101: if (b == 0) r = -1; else r = longint'(a / b);
         3'b110: if (b == 0) r = sa; else r = sa % sb_;
         default: if (b == 0) r = longint'(a); else r = longint'(a % b);
      endcase
      return r[31:0];
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         5: return 32'd0 - 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic scramble();
      bus.funct3 = 3'($urandom);
      bus.a      = $urandom;
      bus.b      = $urandom;
      bus.rd_in  = 5'($urandom);
   endtask

   // Drive one request; leaves the caller just after edge E0.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit exp_done);
      exp_t e;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = f;
      bus.a      = a;
      bus.b      = b;
      bus.rd_in  = rd;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
      if (exp_done) begin
         e.res = ref_op(f, a, b);
         e.rd  = rd;
         e.cyc = cyc + 33;
         sb.push_back(e);
      end
      scramble();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!bus.busy) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still 1 after 60 cycles, expected 0");
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      exp_t e;
      if (busy_chk_pend) begin
         busy_chk_pend = 1'b0;
         chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
      end
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done=1 with result 0x%08h, expected no done", bus.result);
         end else begin
            e = sb.pop_front();
            chk("result", bus.result, e.res);
            chk("rd_out", {27'd0, bus.rd_out}, {27'd0, e.rd});
            chk("latency", cyc, e.cyc);
            busy_chk_pend = 1'b1;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      scramble();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      chk("reset_result", bus.result, 32'd0);
      chk("reset_rd_out", {27'd0, bus.rd_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Basic signed divide, then result/rd_out hold while idle.
      issue(3'b100, 32'd20, 32'd3, 5'd5, 1'b1);
      wait_idle();
      repeat (5) @(negedge clk);
      chk("hold_result", bus.result, 32'd6);
      chk("hold_rd_out", {27'd0, bus.rd_out}, 32'd5);

      // Directed sign / zero-divisor / overflow cases.
      issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd1, 1'b1); wait_idle();
      issue(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd2, 1'b1); wait_idle();
      issue(3'b101, 32'h1234, 32'd0, 5'd3, 1'b1);      wait_idle();
      issue(3'b111, 32'h1234, 32'd0, 5'd4, 1'b1);      wait_idle();
      issue(3'b100, 32'hFFFF_FFF9, 32'd0, 5'd6, 1'b1); wait_idle();
      issue(3'b110, 32'hFFFF_FFF9, 32'd0, 5'd7, 1'b1); wait_idle();
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1); wait_idle();
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1); wait_idle();

      // Start while busy is ignored.
      issue(3'b100, 32'd100, 32'd7, 5'd10, 1'b1);
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = 3'b100;
      bus.a      = 32'd1;
      bus.b      = 32'd1;
      bus.rd_in  = 5'd11;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_idle();

      // Start during the done cycle is ignored.
      issue(3'b101, 32'd50, 32'd5, 5'd12, 1'b1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) break;
      end
      bus.start  = 1'b1;
      bus.funct3 = 3'b100;
      bus.a      = 32'd5;
      bus.b      = 32'd1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("start_in_done_ignored", {31'd0, bus.busy}, 32'd0);

      // Non-divide funct3 values are ignored.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.start  = 1'b1;
         bus.funct3 = 3'(i);
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         chk("bad_funct3_ignored", {31'd0, bus.busy}, 32'd0);
      end

      // Reset at E15 aborts; no done through E40; then a fresh op.
      issue(3'b100, 32'd1000, 32'd9, 5'd13, 1'b0);
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_result", bus.result, 32'd0);
      chk("abort_rd_out", {27'd0, bus.rd_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (26) @(negedge clk);
      issue(3'b100, 32'd9, 32'd3, 5'd14, 1'b1);
      wait_idle();

      // Reset wins over start in the same cycle.
      @(negedge clk);
      rst        = 1'b1;
      bus.start  = 1'b1;
      bus.funct3 = 3'b100;
      @(posedge clk);
      #1;
      chk("rst_priority", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;

      // Randomized operations.
      for (int n = 0; n < 200; n++) begin
         issue(3'($urandom_range(4, 7)), pick(), pick(), 5'($urandom), 1'b1);
         wait_idle();
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
